l15_req_sched: RTL and testbench



---
 rtl/l15_req_sched_pkg.sv | 100 ++++++++++
 rtl/l15_req_credit_cnt.sv | 48 ++++
 rtl/l15_req_sched.sv | 169 ++++++++++++++++
 tb/tb_l15_req_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/l15_req_sched_pkg.sv
// Shared types for the L1.5 request scheduler: cache request payloads, L1.5 request/return
// structs, request-type encodings and the scheduler state enum.
package l15_req_sched_pkg;

    localparam int unsigned DCACHE_MAX_TX    = 4;
    localparam int unsigned L15_TID_WIDTH    = 2;
    localparam int unsigned L15_WAY_WIDTH    = 3;
    localparam int unsigned ICACHE_WAY_WIDTH = 2;
    localparam int unsigned DCACHE_WAY_WIDTH = 2;
    localparam int unsigned ICACHE_PLEN      = 32;
    localparam int unsigned PLEN             = 40;

    localparam logic [2:0] L15_ICACHE_NC_SIZE   = 3'b010;
    localparam logic [2:0] L15_ICACHE_LINE_SIZE = 3'b111;

    typedef enum logic [4:0] {
        L15_LOAD_RQ   = 5'b00000,
        L15_STORE_RQ  = 5'b00001,
        L15_ATOMIC_RQ = 5'b00110,
        L15_INT_RQ    = 5'b01001,
        L15_IMISS_RQ  = 5'b10000
    } l15_reqtypes_t;

    typedef enum logic [1:0] {
        DCACHE_LOAD_REQ,
        DCACHE_STORE_REQ,
        DCACHE_ATOMIC_REQ,
        DCACHE_INT_REQ
    } dcache_out_t;

    typedef enum logic {
        StIdle,
        StHold
    } sched_state_e;

    typedef struct packed {
        logic [ICACHE_WAY_WIDTH-1:0] way;
        logic [ICACHE_PLEN-1:0]      paddr;
        logic                        nc;
        logic [L15_TID_WIDTH-1:0]    tid;
    } icache_req_t;

    typedef struct packed {
        dcache_out_t                 rtype;
        logic [2:0]                  size;
        logic [DCACHE_WAY_WIDTH-1:0] way;
        logic [PLEN-1:0]             paddr;
        logic [63:0]                 data;
        logic                        nc;
        logic [L15_TID_WIDTH-1:0]    tid;
        logic [5:0]                  amo_op;
    } dcache_req_t;

    typedef struct packed {
        logic                     l15_val;
        logic                     l15_req_ack;
        l15_reqtypes_t            l15_rqtype;
        logic                     l15_nc;
        logic [2:0]               l15_size;
        logic [L15_TID_WIDTH-1:0] l15_threadid;
        logic                     l15_prefetch;
        logic                     l15_invalidate_cacheline;
        logic                     l15_blockstore;
        logic                     l15_blockinitstore;
        logic [L15_WAY_WIDTH-1:0] l15_l1rplway;
        logic [39:0]              l15_address;
        logic [63:0]              l15_data;
        logic [63:0]              l15_data_next_entry;
        logic [32:0]              l15_csm_data;
        logic [3:0]               l15_amo_op;
    } l15_req_t;

    typedef struct packed {
        logic        l15_ack;
        logic        l15_header_ack;
        logic        l15_val;
        logic [3:0]  l15_returntype;
        logic [63:0] l15_data_0;
    } l15_rtrn_t;

    function automatic l15_reqtypes_t to_l15_rqtype(input dcache_out_t rtype);
        l15_reqtypes_t res;
        case (rtype)
            DCACHE_STORE_REQ:  res = L15_STORE_RQ;
            DCACHE_ATOMIC_REQ: res = L15_ATOMIC_RQ;
            DCACHE_INT_REQ:    res = L15_INT_RQ;
            default:           res = L15_LOAD_RQ;
        endcase
        return res;
    endfunction

    function automatic logic [63:0] swendian64(input logic [63:0] d);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = d[56-8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/l15_req_credit_cnt.sv
// Saturating up/down credit counter tracking in-flight transactions of one requester.
module l15_req_credit_cnt #(
    parameter int unsigned MAX = 1,
    localparam int unsigned W  = $clog2(MAX + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o,
    output logic         busy_o
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    // A simultaneous grant and completion cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != MaxVal) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == MaxVal);
    assign busy_o = (cnt_q != '0);

    // A completion with nothing outstanding points at an upstream bookkeeping bug.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(dec_i && cnt_q == '0));
        end
    end

endmodule

// File: rtl/l15_req_sched.sv
// Round-robin scheduler of I$ fill and D$ requests onto the single L1.5 request channel,
// with per-requester credit limits; the granted request is held until header_ack.
module l15_req_sched
    import l15_req_sched_pkg::*;
#(
    parameter int unsigned ICACHE_MAX_TX   = 1,
    parameter int unsigned DCACHE_MAX_TX_P = DCACHE_MAX_TX,
    parameter bit          SWAP_ENDIAN     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        icache_req_i,
    input  icache_req_t icache_data_i,
    output logic        icache_ack_o,
    input  logic        dcache_req_i,
    input  dcache_req_t dcache_data_i,
    output logic        dcache_ack_o,
    input  logic        icache_done_i,
    input  logic        dcache_done_i,
    input  logic        rtrn_ack_i,
    output l15_req_t    l15_req_o,
    input  l15_rtrn_t   l15_rtrn_i,
    output logic        icache_busy_o,
    output logic        dcache_busy_o
);

    sched_state_e state_q, state_d;
    logic         rr_q, rr_d;   // 0: D$ wins the next conflict, 1: I$ wins
    l15_req_t     req_q, req_d;
    l15_req_t     ireq, dreq;

    logic [$clog2(ICACHE_MAX_TX+1)-1:0]   icnt;
    logic [$clog2(DCACHE_MAX_TX_P+1)-1:0] dcnt;
    logic icnt_full, dcnt_full;
    logic ielig, delig, igrant, dgrant;

    assign ielig = rst_ni && icache_req_i && !icnt_full;
    assign delig = rst_ni && dcache_req_i && !dcnt_full;

    always_comb begin
        ireq                = '0;
        ireq.l15_val        = 1'b1;
        ireq.l15_rqtype     = L15_IMISS_RQ;
        ireq.l15_nc         = icache_data_i.nc;
        ireq.l15_size       = icache_data_i.nc ? L15_ICACHE_NC_SIZE : L15_ICACHE_LINE_SIZE;
        ireq.l15_threadid   = icache_data_i.tid;
        ireq.l15_l1rplway   = L15_WAY_WIDTH'(icache_data_i.way);
        ireq.l15_address    = 40'(icache_data_i.paddr);
    end

    always_comb begin
        dreq              = '0;
        dreq.l15_val      = 1'b1;
        dreq.l15_rqtype   = to_l15_rqtype(dcache_data_i.rtype);
        dreq.l15_nc       = dcache_data_i.nc;
        dreq.l15_size     = dcache_data_i.size;
        dreq.l15_threadid = dcache_data_i.tid;
        dreq.l15_l1rplway = L15_WAY_WIDTH'(dcache_data_i.way);
        dreq.l15_address  = dcache_data_i.paddr;
        dreq.l15_amo_op   = dcache_data_i.amo_op[3:0];
        if (SWAP_ENDIAN && (dcache_data_i.rtype == DCACHE_STORE_REQ ||
                            dcache_data_i.rtype == DCACHE_ATOMIC_REQ)) begin
            dreq.l15_data = swendian64(dcache_data_i.data);
        end else begin
            dreq.l15_data = dcache_data_i.data;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        req_d   = req_q;
        igrant  = 1'b0;
        dgrant  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ielig && delig) begin
                    igrant = rr_q;
                    dgrant = !rr_q;
                end else begin
                    igrant = ielig;
                    dgrant = delig;
                end
                if (igrant || dgrant) begin
                    req_d   = igrant ? ireq : dreq;
                    rr_d    = dgrant;
                    state_d = StHold;
                end
            end
            StHold: begin
                // No grant in the header_ack cycle keeps requests at least 2 cycles apart.
                if (l15_rtrn_i.l15_header_ack) begin
                    req_d.l15_val = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            req_q   <= req_d;
        end
    end

    l15_req_credit_cnt #(
        .MAX (ICACHE_MAX_TX)
    ) u_icnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (igrant),
        .dec_i  (icache_done_i),
        .cnt_o  (icnt),
        .full_o (icnt_full),
        .busy_o (icache_busy_o)
    );

    l15_req_credit_cnt #(
        .MAX (DCACHE_MAX_TX_P)
    ) u_dcnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (dgrant),
        .dec_i  (dcache_done_i),
        .cnt_o  (dcnt),
        .full_o (dcnt_full),
        .busy_o (dcache_busy_o)
    );

    assign icache_ack_o = igrant;
    assign dcache_ack_o = dgrant;

    always_comb begin
        l15_req_o             = req_q;
        l15_req_o.l15_req_ack = rtrn_ack_i && rst_ni;
    end

    logic unused_inputs;
    assign unused_inputs = ^{l15_rtrn_i.l15_ack, l15_rtrn_i.l15_val, l15_rtrn_i.l15_returntype,
                             l15_rtrn_i.l15_data_0, dcache_data_i.amo_op[5:4]};

    // Previous-cycle copy used only to check that a pending request stays stable.
    logic     hold_chk_q;
    l15_req_t req_prev_q;

    always_ff @(posedge clk_i) begin
        hold_chk_q <= rst_ni && req_q.l15_val && !l15_rtrn_i.l15_header_ack;
        req_prev_q <= req_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(icache_ack_o && dcache_ack_o));
            assert (32'(icnt) <= ICACHE_MAX_TX);
            assert (32'(dcnt) <= DCACHE_MAX_TX_P);
            if (hold_chk_q) begin
                assert (req_q == req_prev_q);
            end
        end
    end

endmodule

// File: tb/tb_l15_req_sched.sv
// Directed bench for l15_req_sched: reset, I$/D$ encoding, round-robin, credits, mid-hold reset.
module tb_l15_req_sched;
    import l15_req_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req, dc_req, ic_ack, dc_ack, ic_done, dc_done, rtrn_ack;
    logic        ic_busy, dc_busy;
    icache_req_t ic_data;
    dcache_req_t dc_data;
    l15_req_t    l15_req;
    l15_rtrn_t   l15_rtrn;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    l15_req_sched dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .icache_req_i  (ic_req),
        .icache_data_i (ic_data),
        .icache_ack_o  (ic_ack),
        .dcache_req_i  (dc_req),
        .dcache_data_i (dc_data),
        .dcache_ack_o  (dc_ack),
        .icache_done_i (ic_done),
        .dcache_done_i (dc_done),
        .rtrn_ack_i    (rtrn_ack),
        .l15_req_o     (l15_req),
        .l15_rtrn_i    (l15_rtrn),
        .icache_busy_o (ic_busy),
        .dcache_busy_o (dc_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; ic_done = 1'b0; dc_done = 1'b0;
        rtrn_ack = 1'b1; l15_rtrn = '0; ic_data = '0; dc_data = '0;

        // Reset with both requesters asserting
        nxt(); ic_req = 1'b1; dc_req = 1'b1;
        nxt(); #1;
        check("rst_val", l15_req.l15_val, 0);
        check("rst_iack", ic_ack, 0);
        check("rst_dack", dc_ack, 0);
        check("rst_req_ack", l15_req.l15_req_ack, 0);
        check("rst_busy", {ic_busy, dc_busy}, 0);
        check("rst_state", dut.state_q, StIdle);
        ic_req = 1'b0; dc_req = 1'b0; rst_n = 1'b1; #1;
        check("req_ack_hi", l15_req.l15_req_ack, 1);
        rtrn_ack = 1'b0; #1;
        check("req_ack_lo", l15_req.l15_req_ack, 0);

        // Single I$ fill, header_ack on the third hold cycle
        nxt();
        ic_data = '{way: 2'd1, paddr: 32'h8000_0040, nc: 1'b0, tid: 2'd0};
        ic_req = 1'b1; #1;
        check("i1_ack", ic_ack, 1);
        check("i1_dack", dc_ack, 0);
        nxt(); ic_req = 1'b0; #1;
        check("i1_val1", l15_req.l15_val, 1);
        check("i1_rqtype", l15_req.l15_rqtype, 5'b10000);
        check("i1_size", l15_req.l15_size, 3'b111);
        check("i1_addr", l15_req.l15_address, 40'h00_8000_0040);
        check("i1_way", l15_req.l15_l1rplway, 1);
        check("i1_data", l15_req.l15_data, 0);
        check("i1_ack_once", ic_ack, 0);
        check("i1_busy", ic_busy, 1);
        nxt(); #1;
        check("i1_val2", l15_req.l15_val, 1);
        nxt(); l15_rtrn.l15_header_ack = 1'b1; #1;
        check("i1_val3", l15_req.l15_val, 1);
        check("i1_addr_hold", l15_req.l15_address, 40'h00_8000_0040);
        nxt(); l15_rtrn.l15_header_ack = 1'b0; #1;
        check("i1_val_off", l15_req.l15_val, 0);

        // I$ credit exhausted; D$ STORE served meanwhile
        nxt(); ic_req = 1'b1; #1;
        check("ifull_noack", ic_ack, 0);
        nxt();
        dc_data = '{rtype: DCACHE_STORE_REQ, size: 3'd3, way: 2'd2, paddr: 40'h12_3456_7008,
                    data: 64'h0011_2233_4455_6677, nc: 1'b0, tid: 2'd1, amo_op: 6'd0};
        dc_req = 1'b1; #1;
        check("st_dack", dc_ack, 1);
        check("st_iack", ic_ack, 0);
        nxt(); dc_req = 1'b0; l15_rtrn.l15_header_ack = 1'b1; #1;
        check("st_val", l15_req.l15_val, 1);
        check("st_rqtype", l15_req.l15_rqtype, 5'b00001);
        check("st_data", l15_req.l15_data, 64'h7766_5544_3322_1100);
        check("st_addr", l15_req.l15_address, 40'h12_3456_7008);
        check("st_way", l15_req.l15_l1rplway, 2);
        check("st_tid", l15_req.l15_threadid, 1);
        check("st_size", l15_req.l15_size, 3);
        nxt(); l15_rtrn.l15_header_ack = 1'b0; #1;
        check("st_val_off", l15_req.l15_val, 0);
        check("ifull_noack2", ic_ack, 0);
        check("st_dbusy", dc_busy, 1);
        nxt(); ic_done = 1'b1; #1;
        check("idone_same_cyc", ic_ack, 0);
        nxt(); ic_done = 1'b0; #1;
        check("idone_ack", ic_ack, 1);
        nxt(); ic_req = 1'b0; l15_rtrn.l15_header_ack = 1'b1; #1;
        check("i2_rqtype", l15_req.l15_rqtype, 5'b10000);
        nxt(); l15_rtrn.l15_header_ack = 1'b0; ic_done = 1'b1; #1;
        check("i2_val_off", l15_req.l15_val, 0);

        // Continuous conflict, header_ack held high: D, I, D, I
        nxt(); ic_done = 1'b0;
        ic_data = '{way: 2'd0, paddr: 32'h0000_1000, nc: 1'b0, tid: 2'd0};
        dc_data = '{rtype: DCACHE_LOAD_REQ, size: 3'd3, way: 2'd0, paddr: 40'h00_0000_2000,
                    data: 64'h0011_2233_4455_6677, nc: 1'b0, tid: 2'd0, amo_op: 6'd0};
        ic_req = 1'b1; dc_req = 1'b1; l15_rtrn.l15_header_ack = 1'b1; #1;
        check("rr0_dack", dc_ack, 1);
        check("rr0_iack", ic_ack, 0);
        nxt(); #1;
        check("rr0_val", l15_req.l15_val, 1);
        check("rr0_rqtype", l15_req.l15_rqtype, 5'b00000);
        check("ld_data", l15_req.l15_data, 64'h0011_2233_4455_6677);
        check("rr0_noack", {ic_ack, dc_ack}, 0);
        nxt(); #1;
        check("rr1_gap", l15_req.l15_val, 0);
        check("rr1_iack", ic_ack, 1);
        check("rr1_dack", dc_ack, 0);
        nxt(); ic_done = 1'b1; ic_data.nc = 1'b1; #1;
        check("rr1_rqtype", l15_req.l15_rqtype, 5'b10000);
        check("rr1_size", l15_req.l15_size, 3'b111);
        nxt(); ic_done = 1'b0; #1;
        check("rr2_gap", l15_req.l15_val, 0);
        check("rr2_dack", dc_ack, 1);
        check("rr2_iack", ic_ack, 0);
        nxt(); #1;
        check("rr2_val", l15_req.l15_val, 1);
        nxt(); #1;
        check("rr3_gap", l15_req.l15_val, 0);
        check("rr3_iack", ic_ack, 1);
        nxt(); ic_req = 1'b0; dc_req = 1'b0; ic_done = 1'b1; #1;
        check("nc_size", l15_req.l15_size, 3'b010);
        check("nc_flag", l15_req.l15_nc, 1);
        nxt(); ic_done = 1'b0; l15_rtrn.l15_header_ack = 1'b0; dc_done = 1'b1; #1;
        check("rr_end_val", l15_req.l15_val, 0);
        nxt(); dc_done = 1'b0; #1;
        check("dcnt_2", dut.u_dcnt.cnt_o, 2);

        // Grant and completion in the same cycle; ATOMIC encoding
        nxt();
        dc_data = '{rtype: DCACHE_ATOMIC_REQ, size: 3'd3, way: 2'd3, paddr: 40'h00_0000_3010,
                    data: 64'h0102_0304_0506_0708, nc: 1'b1, tid: 2'd2, amo_op: 6'h3B};
        dc_req = 1'b1; dc_done = 1'b1; #1;
        check("gd_dack", dc_ack, 1);
        nxt(); dc_req = 1'b0; dc_done = 1'b0; #1;
        check("gd_dcnt", dut.u_dcnt.cnt_o, 2);
        check("amo_val", l15_req.l15_val, 1);
        check("amo_rqtype", l15_req.l15_rqtype, 5'b00110);
        check("amo_data", l15_req.l15_data, 64'h0807_0605_0403_0201);
        check("amo_op", l15_req.l15_amo_op, 4'hB);

        // Reset while holding a request
        rst_n = 1'b0; rtrn_ack = 1'b1; ic_req = 1'b1; dc_req = 1'b1;
        nxt(); #1;
        check("mrst_val", l15_req.l15_val, 0);
        check("mrst_busy", {ic_busy, dc_busy}, 0);
        check("mrst_state", dut.state_q, StIdle);
        check("mrst_req_ack", l15_req.l15_req_ack, 0);
        check("mrst_acks", {ic_ack, dc_ack}, 0);
        rst_n = 1'b1; #1;
        check("post_req_ack", l15_req.l15_req_ack, 1);
        check("post_dack", dc_ack, 1);
        check("post_iack", ic_ack, 0);
        nxt(); ic_req = 1'b0; dc_req = 1'b0; #1;
        check("post_val", l15_req.l15_val, 1);
        check("post_rqtype", l15_req.l15_rqtype, 5'b00110);
        check("post_dbusy", dc_busy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
